// File: rtl/ps_window3x3_pkg.sv
// ps_window3x3 shared definitions.
// Pixel defaults, FSM encoding and 3x3 window tap indices.
package ps_pkg;

    localparam int PIXEL_W   = 12;
    localparam int DEF_IMG_W = 640;
    localparam int DEF_IMG_H = 480;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BURST   = 2'd1,
        ST_ROW_END = 2'd2
    } state_e;

    // Tap k = r*3 + c; r=0 oldest row, c=0 oldest column.
    localparam int TAP_TL = 0;
    localparam int TAP_T  = 1;
    localparam int TAP_TR = 2;
    localparam int TAP_L  = 3;
    localparam int TAP_C  = 4;
    localparam int TAP_R  = 5;
    localparam int TAP_BL = 6;
    localparam int TAP_B  = 7;
    localparam int TAP_BR = 8;

endpackage

// File: rtl/ps_window3x3_if.sv
// ps_window3x3 stream bundle.
// Upstream FIFO read side plus downstream window side.
interface ps_window3x3_if #(
    parameter int DATA_W = ps_pkg::PIXEL_W
);
    logic                  o_rd;
    logic [DATA_W-1:0]     i_data;
    logic                  i_valid;
    logic                  i_empty;
    logic                  i_ready;
    logic [9*DATA_W-1:0]   o_win;
    logic                  o_valid;
    logic                  o_sof;
    logic                  o_eol;

    modport master (
        output o_rd, o_win, o_valid, o_sof, o_eol,
        input  i_data, i_valid, i_empty, i_ready
    );

    modport slave (
        input  o_rd, o_win, o_valid, o_sof, o_eol,
        output i_data, i_valid, i_empty, i_ready
    );

endinterface

// File: rtl/ps_linebuf_ram.sv
// ps_linebuf_ram: simple dual-port line buffer.
// Read-first, registered read, contents never cleared.
module ps_linebuf_ram #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 640,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Write and read in the same edge; read returns the old word.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ps_window3x3.sv
// ps_window3x3: streaming 3x3 window generator.
// Pulls one row per burst, two line buffers hold rows n-1/n-2.
module ps_window3x3
    import ps_pkg::*;
#(
    parameter int DATA_W = PIXEL_W,
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int ADDR_W = 10
) (
    input  logic           i_clk,
    input  logic           i_rst,
    ps_window3x3_if.master bus
);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] WIN_COL  = ADDR_W'(2);
    localparam logic [ROW_W-1:0]  WIN_ROW  = ROW_W'(2);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic                sel_q, sel_d;
    logic                acc1_q, acc1_d;
    logic [DATA_W-1:0]   pix1_q, pix1_d;
    logic                val1_q, val1_d;
    logic                sof1_q, sof1_d;
    logic                eol1_q, eol1_d;
    logic [8:0][DATA_W-1:0] win_q, win_d;
    logic                vld_q, vld_d;
    logic                sof_q, sof_d;
    logic                eol_q, eol_d;

    logic                rd;
    logic                acc;
    logic [DATA_W-1:0]   q0, q1;
    logic [DATA_W-1:0]   lb_a, lb_b;

    assign rd  = (state_q == ST_BURST) && !bus.i_empty
                 && bus.i_ready && !i_rst;
    assign acc = rd && bus.i_valid;

    // sel=0: ram0 is row n-1 (LB_A), ram1 is row n-2 (LB_B).
    assign lb_a = sel_q ? q1 : q0;
    assign lb_b = sel_q ? q0 : q1;

    ps_linebuf_ram #(
        .DATA_W(DATA_W), .DEPTH(IMG_W), .ADDR_W(ADDR_W)
    ) u_ram0 (
        .clk(i_clk), .we(acc && sel_q), .waddr(col_q),
        .wdata(bus.i_data), .re(acc), .raddr(col_q),
        .rdata(q0)
    );

    ps_linebuf_ram #(
        .DATA_W(DATA_W), .DEPTH(IMG_W), .ADDR_W(ADDR_W)
    ) u_ram1 (
        .clk(i_clk), .we(acc && !sel_q), .waddr(col_q),
        .wdata(bus.i_data), .re(acc), .raddr(col_q),
        .rdata(q1)
    );

    // Row sequencing: burst of IMG_W accepts, then one swap cycle.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        sel_d   = sel_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!bus.i_empty && bus.i_ready) state_d = ST_BURST;
            end
            ST_BURST: begin
                if (acc) begin
                    if (col_q == LAST_COL) state_d = ST_ROW_END;
                    else col_d = col_q + ADDR_W'(1);
                end
            end
            ST_ROW_END: begin
                col_d   = '0;
                sel_d   = !sel_q;
                row_d   = (row_q == LAST_ROW) ? '0
                                              : row_q + ROW_W'(1);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Window pipeline: tag at accept, shift column on RAM return.
    always_comb begin
        acc1_d = acc;
        pix1_d = acc ? bus.i_data : pix1_q;
        val1_d = acc && (row_q >= WIN_ROW) && (col_q >= WIN_COL);
        sof1_d = acc && (row_q == WIN_ROW) && (col_q == WIN_COL);
        eol1_d = acc && (col_q == LAST_COL);
        win_d  = win_q;
        if (acc1_q) begin
            win_d[TAP_TL] = win_q[TAP_T];
            win_d[TAP_T]  = win_q[TAP_TR];
            win_d[TAP_TR] = lb_b;
            win_d[TAP_L]  = win_q[TAP_C];
            win_d[TAP_C]  = win_q[TAP_R];
            win_d[TAP_R]  = lb_a;
            win_d[TAP_BL] = win_q[TAP_B];
            win_d[TAP_B]  = win_q[TAP_BR];
            win_d[TAP_BR] = pix1_q;
        end
        vld_d = val1_q;
        sof_d = sof1_q;
        eol_d = eol1_q;
    end

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            sel_q   <= 1'b0;
            acc1_q  <= 1'b0;
            pix1_q  <= '0;
            val1_q  <= 1'b0;
            sof1_q  <= 1'b0;
            eol1_q  <= 1'b0;
            win_q   <= '0;
            vld_q   <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            sel_q   <= sel_d;
            acc1_q  <= acc1_d;
            pix1_q  <= pix1_d;
            val1_q  <= val1_d;
            sof1_q  <= sof1_d;
            eol1_q  <= eol1_d;
            win_q   <= win_d;
            vld_q   <= vld_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
        end
    end

    assign bus.o_rd    = rd;
    assign bus.o_win   = win_q;
    assign bus.o_valid = vld_q;
    assign bus.o_sof   = sof_q;
    assign bus.o_eol   = eol_q;

endmodule
